// File: rtl/biquad_coeff_bank_pkg.sv
// Shared definitions for the biquad coefficient bank: coefficient addresses,
// passthrough reset values, coefficient type and the commit FSM state type.
package biquad_coeff_bank_pkg;

  localparam int unsigned COEF_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_COEF = 5;

  localparam logic [ADDR_W-1:0] COEF_B0 = 3'd0;
  localparam logic [ADDR_W-1:0] COEF_B1 = 3'd1;
  localparam logic [ADDR_W-1:0] COEF_B2 = 3'd2;
  localparam logic [ADDR_W-1:0] COEF_A1 = 3'd3;
  localparam logic [ADDR_W-1:0] COEF_A2 = 3'd4;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Reset gives a passthrough filter: b0 = ~1.0, all other taps zero.
  localparam coef_t RST_B0    = 16'sh7FFF;
  localparam coef_t RST_OTHER = 16'sh0000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  function automatic coef_t coef_reset_val(input logic [ADDR_W-1:0] addr);
    return (addr == COEF_B0) ? RST_B0 : RST_OTHER;
  endfunction

endpackage

// File: rtl/biquad_coeff_bank_if.sv
// Host write channel into the coefficient bank (valid/ready handshake).
//   wr_valid : host write request
//   wr_ready : bank can accept a write this cycle
//   wr_addr  : coefficient select (0=b0 .. 4=a2, 5..7 invalid)
//   wr_data  : signed Q1.15 coefficient value
interface biquad_coeff_bank_if;
  import biquad_coeff_bank_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  coef_t             wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/biquad_coeff_bank.sv
// Double-buffered biquad coefficient bank. The host writes a shadow set; a
// commit publishes it to the active set atomically at the next sample strobe,
// so the filter never sees a half-updated coefficient set.
//   clk, rst_n        : clock, async active-low reset
//   wr_if             : host write channel (slave side)
//   commit_req        : request to publish the shadow set
//   sample_strobe     : filter sample boundary
//   b0, b1, b2, a1, a2: active coefficients (registered)
//   commit_pending    : commit waiting for a sample boundary
//   commit_done       : pulse the cycle after the active set updates
//   addr_err          : pulse the cycle after a write to an invalid address
module biquad_coeff_bank
  import biquad_coeff_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  biquad_coeff_bank_if.slave   wr_if,
  input  logic                 commit_req,
  input  logic                 sample_strobe,
  output coef_t                b0,
  output coef_t                b1,
  output coef_t                b2,
  output coef_t                a1,
  output coef_t                a2,
  output logic                 commit_pending,
  output logic                 commit_done,
  output logic                 addr_err
);

  state_e state_q, state_d;
  coef_t  shadow_q [NUM_COEF];
  coef_t  shadow_d [NUM_COEF];
  coef_t  active_q [NUM_COEF];
  coef_t  active_d [NUM_COEF];
  logic   wr_ready_q, wr_ready_d;
  logic   commit_pending_q, commit_pending_d;
  logic   commit_done_q, commit_done_d;
  logic   addr_err_q, addr_err_d;
  logic   wr_fire;
  logic   addr_ok;

  // State and bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      wr_ready_q       <= 1'b1;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      addr_err_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= coef_reset_val(ADDR_W'(i));
        active_q[i] <= coef_reset_val(ADDR_W'(i));
      end
    end else begin
      state_q          <= state_d;
      wr_ready_q       <= wr_ready_d;
      commit_pending_q <= commit_pending_d;
      commit_done_q    <= commit_done_d;
      addr_err_q       <= addr_err_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
    end
  end

  // Next-state, bank update and registered-output next values.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_done_d = 1'b0;

    // wr_ready_q mirrors state_q == ST_IDLE, so writes only land in IDLE.
    wr_fire    = wr_if.wr_valid && wr_ready_q;
    addr_ok    = (wr_if.wr_addr <= COEF_A2);
    addr_err_d = wr_fire && !addr_ok;

    if (wr_fire && addr_ok) begin
      shadow_d[wr_if.wr_addr] = wr_if.wr_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A strobe in the commit_req cycle is ignored; the swap waits for the next one.
        if (commit_req) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (sample_strobe) begin
          active_d      = shadow_q;
          commit_done_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ready_d       = (state_d == ST_IDLE);
    commit_pending_d = (state_d == ST_PENDING);
  end

  assign wr_if.wr_ready = wr_ready_q;
  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;
  assign addr_err       = addr_err_q;

  assign b0 = active_q[COEF_B0];
  assign b1 = active_q[COEF_B1];
  assign b2 = active_q[COEF_B2];
  assign a1 = active_q[COEF_A1];
  assign a2 = active_q[COEF_A2];

endmodule

// File: doc/biquad_coeff_bank.md
BIQUAD_COEFF_BANK -- requirements
Module: biquad_coeff_bank

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port wr_valid, input, 1: host write request.
REQ-004 SHALL have port wr_ready, output, 1: write accepted when wr_valid && wr_ready.
REQ-005 SHALL have port wr_addr, input, 3: coefficient select, 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 invalid.
REQ-006 SHALL have port wr_data, input, 16: signed Q1.15 coefficient value.
REQ-007 SHALL have port commit_req, input, 1: single-cycle request to publish the shadow set.
REQ-008 SHALL have port sample_strobe, input, 1: the filter's in_valid; marks sample boundaries.
REQ-009 SHALL have ports b0, b1, b2, a1, a2, output, 16 each, signed: active coefficients driven to the filter.
REQ-010 SHALL have port commit_pending, output, 1: high while a commit awaits a sample boundary.
REQ-011 SHALL have port commit_done, output, 1: one-cycle pulse on the cycle after the active set updates.
REQ-012 SHALL have port addr_err, output, 1: one-cycle pulse after an accepted write to address 5..7.

Function
REQ-013 SHALL hold two register sets, shadow and active, of five 16-bit coefficients each.
REQ-014 SHALL use a two-state FSM: IDLE and PENDING.
REQ-015 In IDLE: wr_ready=1; an accepted write to address 0..4 updates that shadow coefficient at the clock edge; active is unchanged.
REQ-016 An accepted write to address 5..7 SHALL be discarded; addr_err pulses high the following cycle.
REQ-017 IDLE->PENDING on commit_req=1; a write accepted in the same cycle SHALL land in shadow and be part of the commit.
REQ-018 In PENDING: wr_ready=0, commit_pending=1, commit_req ignored.
REQ-019 PENDING->IDLE on the first cycle with sample_strobe=1: all five active registers load shadow at that edge, atomically.
REQ-020 The filter SHALL use old coefficients for the strobed sample in the swap cycle; new ones apply from the next sample.
REQ-021 commit_req and sample_strobe together in IDLE SHALL NOT swap that cycle; the swap occurs on the next strobe.
REQ-022 commit_done SHALL pulse exactly once per swap, in the cycle after the swap edge.
REQ-023 Outputs b0..a2 SHALL be registered directly from the active set, with no combinational path from any input.
REQ-024 PENDING SHALL have no timeout; with no strobe it holds indefinitely.

Reset
REQ-025 On rst_n low, immediately: shadow and active b0=16'h7FFF and b1,b2,a1,a2=0 (passthrough); FSM=IDLE; commit_pending=0, commit_done=0, addr_err=0. wr_ready=1 after reset release.
REQ-026 Reset asserted in PENDING SHALL discard the pending commit and restore the reset values in both sets.

Structure
REQ-027 A shared package SHALL hold the coefficient address constants (COEF_B0..COEF_A2), the reset value constants, and the FSM state typedef.
REQ-028 SHALL be a single module with no sub-modules; the five-entry bank is indexed by address.

Verification
REQ-029 Reset: after release, b0=0x7FFF, b1..a2=0x0000, wr_ready=1, commit_pending=0.
REQ-030 Write b0=0x4000, a1=0xC000, commit, strobe 3 cycles later: outputs unchanged until the strobe edge; then b0=0x4000, a1=0xC000; commit_done pulses once; wr_ready returns to 1.
REQ-031 Write to addr 6 with data 0x1234: no coefficient changes, addr_err is a 1-cycle pulse.
REQ-032 wr_valid (addr 2, 0x2000) with commit_req in the same cycle, then strobe: b2=0x2000 after the swap; a write attempted during PENDING sees wr_ready=0 and is not accepted.
REQ-033 commit_req with sample_strobe in the same cycle in IDLE: no swap; the next strobe swaps.
REQ-034 rst_n pulsed low while PENDING: commit_pending=0, all coefficients at reset values, and no commit_done pulse on the following strobe.
